// File: rtl/loop_sequencer.sv
// Counted-loop controller: drives the index counter's preload/clear/increment
// strobes, launches loop-body iterations and guards each one with a watchdog.
module loop_sequencer #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             Clk,
   input  logic             RSTn,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] first,
   input  logic [WIDTH-1:0] limit,
   input  logic             body_done,
   input  logic             z_in,
   output logic             cnt_wen,
   output logic             cnt_rst,
   output logic             cnt_inc,
   output logic [WIDTH-1:0] cnt_bus,
   output logic [WIDTH-1:0] cnt_din,
   output logic             body_start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] iter_count
);

   // state  | meaning
   // IDLE   | waiting for start
   // LOAD   | preload (cnt_wen) or clear (cnt_rst) the index counter
   // SETTLE | counter updates index and compare flag
   // CHECK  | sample z_in: finish or launch another iteration
   // BODY   | body running, watchdog counting
   // STEP   | increment the index
   // DONE   | one-cycle completion pulse
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      BODY   = 3'd4,
      STEP   = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam int WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];

   state_t           state, state_nxt;
   logic [WD_W-1:0]  wd, wd_nxt;
   logic [WIDTH-1:0] bus_nxt, din_nxt, iter_nxt;
   logic             err_nxt;
   logic             wen_nxt, rst_nxt, inc_nxt, bstart_nxt, done_nxt;

   always_comb begin
      state_nxt  = state;
      wd_nxt     = wd;
      bus_nxt    = cnt_bus;
      din_nxt    = cnt_din;
      iter_nxt   = iter_count;
      err_nxt    = err;
      wen_nxt    = 1'b0;
      rst_nxt    = 1'b0;
      inc_nxt    = 1'b0;
      bstart_nxt = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = LOAD;
               bus_nxt   = first;
               din_nxt   = limit;
               iter_nxt  = '0;
               err_nxt   = 1'b0;
               rst_nxt   = (first == '0);
               wen_nxt   = (first != '0);
            end
         end
         LOAD:   state_nxt = SETTLE;
         SETTLE: state_nxt = CHECK;
         CHECK: begin
            if (z_in) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end else begin
               state_nxt  = BODY;
               bstart_nxt = 1'b1;
               wd_nxt     = '0;
            end
         end
         BODY: begin
            // body_done beats a timeout landing in the same cycle
            if (body_done) begin
               state_nxt = STEP;
               inc_nxt   = 1'b1;
               iter_nxt  = iter_count + 1'b1;
            end else if (TIMEOUT != 0 && wd == WD_LAST) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end else begin
               wd_nxt = wd + 1'b1;
            end
         end
         STEP:    state_nxt = SETTLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort && state != IDLE) begin
         state_nxt  = IDLE;
         iter_nxt   = iter_count;
         err_nxt    = err;
         wen_nxt    = 1'b0;
         rst_nxt    = 1'b0;
         inc_nxt    = 1'b0;
         bstart_nxt = 1'b0;
         done_nxt   = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge RSTn) begin
      if (!RSTn) begin
         state      <= IDLE;
         wd         <= '0;
         cnt_bus    <= '0;
         cnt_din    <= '0;
         iter_count <= '0;
         err        <= 1'b0;
         cnt_wen    <= 1'b0;
         cnt_rst    <= 1'b0;
         cnt_inc    <= 1'b0;
         body_start <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         wd         <= wd_nxt;
         cnt_bus    <= bus_nxt;
         cnt_din    <= din_nxt;
         iter_count <= iter_nxt;
         err        <= err_nxt;
         cnt_wen    <= wen_nxt;
         cnt_rst    <= rst_nxt;
         cnt_inc    <= inc_nxt;
         body_start <= bstart_nxt;
         done       <= done_nxt;
         busy       <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer: index counter model, body executor, and a
// scoreboard of expected loop outcomes compared when each loop ends.
module tb_loop_sequencer;
   localparam int W  = 8;
   localparam int TO = 8;

   logic         Clk;
   logic         RSTn = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] first = '0;
   logic [W-1:0] limit = '0;
   logic         body_done;
   logic         z_in;
   logic         cnt_wen, cnt_rst, cnt_inc, body_start, busy, done, err;
   logic [W-1:0] cnt_bus, cnt_din, iter_count;

   loop_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .Clk(Clk), .RSTn(RSTn), .start(start), .abort(abort),
      .first(first), .limit(limit), .body_done(body_done), .z_in(z_in),
      .cnt_wen(cnt_wen), .cnt_rst(cnt_rst), .cnt_inc(cnt_inc),
      .cnt_bus(cnt_bus), .cnt_din(cnt_din), .body_start(body_start),
      .busy(busy), .done(done), .err(err), .iter_count(iter_count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // index counter register model
   logic [W-1:0] idx;
   always @(posedge Clk or negedge RSTn) begin
      if (!RSTn)        idx <= '0;
      else if (cnt_rst) idx <= '0;
      else if (cnt_wen) idx <= cnt_bus;
      else if (cnt_inc) idx <= idx + 1'b1;
   end
   assign z_in = (cnt_din <= idx);

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // pulse monitor, sampled just after each rising edge
   int n_rst = 0, n_wen = 0, n_inc = 0, n_bs = 0, n_done = 0;
   int done_cyc = -1, err_cyc = -1, wen_bus = -1;
   int bs_cyc[$];
   logic err_q = 1'b0;
   always begin
      @(posedge Clk);
      #1;
      if (cnt_rst === 1'b1) n_rst++;
      if (cnt_wen === 1'b1) begin n_wen++; wen_bus = int'(cnt_bus); end
      if (cnt_inc === 1'b1) n_inc++;
      if (body_start === 1'b1) begin n_bs++; bs_cyc.push_back(cyc); end
      if (done === 1'b1) begin n_done++; done_cyc = cyc; end
      if (err === 1'b1 && err_q !== 1'b1) err_cyc = cyc;
      err_q = err;
   end

   // body executor: body_done bd_delay cycles after body_start (0 = same cycle)
   int rsp_seen = 0, rsp_cnt = 0, bd_delay = 2, withhold_idx = -1;
   bit pending = 1'b0;
   initial begin
      body_done = 1'b0;
      forever begin
         @(negedge Clk);
         body_done = 1'b0;
         if (RSTn !== 1'b1 || busy !== 1'b1) pending = 1'b0;
         if (busy === 1'b1 && body_start === 1'b1) begin
            rsp_seen++;
            if (rsp_seen != withhold_idx) begin
               pending = 1'b1;
               rsp_cnt = bd_delay;
            end
         end
         if (pending) begin
            if (rsp_cnt == 0) begin body_done = 1'b1; pending = 1'b0; end
            else rsp_cnt--;
         end
      end
   end

   typedef struct packed {
      int iters; int bs; int incs; int rsts; int wens; int dones; int errf;
   } res_t;
   res_t exp_q[$];

   int n_checks = 0, n_pass = 0;
   int s_rst, s_wen, s_inc, s_bs, s_done;

   task automatic snap();
      s_rst = n_rst; s_wen = n_wen; s_inc = n_inc; s_bs = n_bs; s_done = n_done;
   endtask

   function automatic res_t collect();
      res_t r;
      r.iters = int'(iter_count);
      r.bs    = n_bs - s_bs;
      r.incs  = n_inc - s_inc;
      r.rsts  = n_rst - s_rst;
      r.wens  = n_wen - s_wen;
      r.dones = n_done - s_done;
      r.errf  = int'(err);
      return r;
   endfunction

   function automatic int bs_at(input int k);
      return (bs_cyc.size() > k) ? bs_cyc[k] : -1;
   endfunction

   task automatic kick(input logic [W-1:0] f, input logic [W-1:0] l, output int t0);
      @(negedge Clk);
      first = f; limit = l; start = 1'b1; t0 = cyc;
      @(negedge Clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit expired);
      expired = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (busy === 1'b0) begin expired = 1'b0; break; end
         @(negedge Clk);
      end
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      repeat (3) @(negedge Clk);
      n_checks++;
      if ({cnt_wen, cnt_rst, cnt_inc, body_start, busy, done, err} !== 7'b0)
         $display("FAIL reset_flags: got %b want 0000000", {cnt_wen, cnt_rst, cnt_inc, body_start, busy, done, err});
      else n_pass++;
      n_checks++;
      if ({cnt_bus, cnt_din, iter_count} !== {3*W{1'b0}})
         $display("FAIL reset_data: got bus=%0d din=%0d iter=%0d want 0/0/0", cnt_bus, cnt_din, iter_count);
      else n_pass++;
      RSTn = 1'b1;
      repeat (2) @(negedge Clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy);
      else n_pass++;
   endtask

   task automatic test_basic();
      int t0; bit ex; res_t got, e;
      bd_delay = 2; withhold_idx = -1;
      snap();
      exp_q.push_back('{iters:3, bs:3, incs:3, rsts:1, wens:0, dones:1, errf:0});
      kick(8'd0, 8'd3, t0);
      wait_idle(200, ex);
      got = collect(); e = exp_q.pop_front();
      n_checks++;
      if (ex !== 1'b0) $display("FAIL basic_end: loop still busy after budget");
      else n_pass++;
      n_checks++;
      if (got !== e)
         $display("FAIL basic_result: got it=%0d bs=%0d inc=%0d rst=%0d wen=%0d done=%0d err=%0d want it=%0d bs=%0d inc=%0d rst=%0d wen=%0d done=%0d err=%0d",
                  got.iters, got.bs, got.incs, got.rsts, got.wens, got.dones, got.errf,
                  e.iters, e.bs, e.incs, e.rsts, e.wens, e.dones, e.errf);
      else n_pass++;
      n_checks++;
      if (bs_at(s_bs) !== t0 + 4) $display("FAIL basic_first_latency: got cycle %0d want %0d", bs_at(s_bs), t0 + 4);
      else n_pass++;
      n_checks++;
      if (bs_at(s_bs + 1) !== t0 + 10) $display("FAIL basic_iter_spacing: got cycle %0d want %0d", bs_at(s_bs + 1), t0 + 10);
      else n_pass++;
      n_checks++;
      if (done_cyc !== t0 + 22) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, t0 + 22);
      else n_pass++;
   endtask

   task automatic test_zero_iter();
      int t0; bit ex; res_t got, e;
      snap();
      exp_q.push_back('{iters:0, bs:0, incs:0, rsts:0, wens:1, dones:1, errf:0});
      kick(8'd5, 8'd5, t0);
      wait_idle(50, ex);
      got = collect(); e = exp_q.pop_front();
      n_checks++;
      if (ex !== 1'b0 || got !== e)
         $display("FAIL zero_equal_result: got it=%0d bs=%0d wen=%0d done=%0d err=%0d want it=%0d bs=%0d wen=%0d done=%0d err=%0d",
                  got.iters, got.bs, got.wens, got.dones, got.errf, e.iters, e.bs, e.wens, e.dones, e.errf);
      else n_pass++;
      n_checks++;
      if (done_cyc !== t0 + 4) $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, t0 + 4);
      else n_pass++;
      n_checks++;
      if (wen_bus !== 5) $display("FAIL zero_wen_bus: got %0d want 5", wen_bus);
      else n_pass++;
      snap();
      exp_q.push_back('{iters:0, bs:0, incs:0, rsts:0, wens:1, dones:1, errf:0});
      kick(8'd7, 8'd3, t0);
      wait_idle(50, ex);
      got = collect(); e = exp_q.pop_front();
      n_checks++;
      if (ex !== 1'b0 || got !== e)
         $display("FAIL zero_above_result: got it=%0d bs=%0d wen=%0d done=%0d want it=%0d bs=%0d wen=%0d done=%0d",
                  got.iters, got.bs, got.wens, got.dones, e.iters, e.bs, e.wens, e.dones);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int t0; bit ex; res_t got, e;
      bd_delay = 2; withhold_idx = rsp_seen + 2;
      snap();
      exp_q.push_back('{iters:1, bs:2, incs:1, rsts:0, wens:1, dones:0, errf:1});
      kick(8'd2, 8'd4, t0);
      wait_idle(200, ex);
      got = collect(); e = exp_q.pop_front();
      n_checks++;
      if (ex !== 1'b0 || got !== e)
         $display("FAIL timeout_result: got it=%0d bs=%0d inc=%0d done=%0d err=%0d busy=%b want it=%0d bs=%0d inc=%0d done=%0d err=%0d busy=0",
                  got.iters, got.bs, got.incs, got.dones, got.errf, busy, e.iters, e.bs, e.incs, e.dones, e.errf);
      else n_pass++;
      n_checks++;
      if (err_cyc !== bs_at(s_bs + 1) + TO)
         $display("FAIL timeout_err_cycle: got %0d want %0d", err_cyc, bs_at(s_bs + 1) + TO);
      else n_pass++;
      withhold_idx = -1;
      snap();
      exp_q.push_back('{iters:1, bs:1, incs:1, rsts:1, wens:0, dones:1, errf:0});
      kick(8'd0, 8'd1, t0);
      n_checks++;
      if (err !== 1'b0) $display("FAIL timeout_err_clear: got %b want 0", err);
      else n_pass++;
      wait_idle(100, ex);
      got = collect(); e = exp_q.pop_front();
      n_checks++;
      if (ex !== 1'b0 || got !== e)
         $display("FAIL timeout_rerun_result: got it=%0d bs=%0d done=%0d err=%0d want it=%0d bs=%0d done=%0d err=%0d",
                  got.iters, got.bs, got.dones, got.errf, e.iters, e.bs, e.dones, e.errf);
      else n_pass++;
   endtask

   task automatic test_abort();
      int t0, seen; res_t got, e;
      bd_delay = 3;
      snap();
      exp_q.push_back('{iters:2, bs:3, incs:2, rsts:1, wens:0, dones:0, errf:0});
      kick(8'd0, 8'd10, t0);
      seen = 0;
      for (int i = 0; i < 200 && seen < 3; i++) begin
         @(negedge Clk);
         start = 1'b0;
         if (body_start === 1'b1) seen++;
         if (body_start === 1'b1 && seen == 1) begin
            start = 1'b1; first = 8'd9; limit = 8'd1;
         end
      end
      start = 1'b0;
      n_checks++;
      if (seen !== 3) $display("FAIL abort_reach_body3: got %0d body_starts want 3", seen);
      else n_pass++;
      abort = 1'b1;
      @(negedge Clk);
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL abort_idle_next: busy got %b want 0", busy);
      else n_pass++;
      repeat (6) @(negedge Clk);
      got = collect(); e = exp_q.pop_front();
      n_checks++;
      if (got !== e)
         $display("FAIL abort_result: got it=%0d bs=%0d inc=%0d done=%0d err=%0d want it=%0d bs=%0d inc=%0d done=%0d err=%0d",
                  got.iters, got.bs, got.incs, got.dones, got.errf, e.iters, e.bs, e.incs, e.dones, e.errf);
      else n_pass++;
      n_checks++;
      if (cnt_bus !== 8'd0 || cnt_din !== 8'd10)
         $display("FAIL abort_latched_operands: got bus=%0d din=%0d want 0/10", cnt_bus, cnt_din);
      else n_pass++;
      @(negedge Clk);
      start = 1'b1; abort = 1'b1; first = 8'd1; limit = 8'd2;
      @(negedge Clk);
      start = 1'b0; abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || cnt_din !== 8'd10)
         $display("FAIL abort_beats_start: got busy=%b din=%0d want 0/10", busy, cnt_din);
      else n_pass++;
   endtask

   task automatic test_coincident();
      int t0; bit ex; res_t got, e;
      bd_delay = TO - 1;
      snap();
      exp_q.push_back('{iters:2, bs:2, incs:2, rsts:1, wens:0, dones:1, errf:0});
      kick(8'd0, 8'd2, t0);
      wait_idle(200, ex);
      got = collect(); e = exp_q.pop_front();
      n_checks++;
      if (ex !== 1'b0 || got !== e)
         $display("FAIL coincident_timeout_result: got it=%0d inc=%0d done=%0d err=%0d want it=%0d inc=%0d done=%0d err=%0d",
                  got.iters, got.incs, got.dones, got.errf, e.iters, e.incs, e.dones, e.errf);
      else n_pass++;
      bd_delay = 0;
      snap();
      exp_q.push_back('{iters:3, bs:3, incs:3, rsts:0, wens:1, dones:1, errf:0});
      kick(8'd3, 8'd6, t0);
      wait_idle(200, ex);
      got = collect(); e = exp_q.pop_front();
      n_checks++;
      if (ex !== 1'b0 || got !== e)
         $display("FAIL coincident_start_result: got it=%0d bs=%0d inc=%0d done=%0d want it=%0d bs=%0d inc=%0d done=%0d",
                  got.iters, got.bs, got.incs, got.dones, e.iters, e.bs, e.incs, e.dones);
      else n_pass++;
      n_checks++;
      if (bs_at(s_bs + 1) - bs_at(s_bs) !== 4)
         $display("FAIL coincident_start_spacing: got %0d want 4", bs_at(s_bs + 1) - bs_at(s_bs));
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int t0; bit ex, hit; res_t got, e;
      bd_delay = 1;
      kick(8'd0, 8'd3, t0);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge Clk);
         if (cnt_inc === 1'b1) hit = 1'b1;
      end
      n_checks++;
      if (hit !== 1'b1) $display("FAIL midreset_reach_step: cnt_inc never seen");
      else n_pass++;
      RSTn = 1'b0;
      #1;
      n_checks++;
      if ({cnt_wen, cnt_rst, cnt_inc, body_start, busy, done, err} !== 7'b0 ||
          {cnt_bus, cnt_din, iter_count} !== {3*W{1'b0}})
         $display("FAIL midreset_outputs: got flags=%b bus=%0d din=%0d iter=%0d want 0",
                  {cnt_wen, cnt_rst, cnt_inc, body_start, busy, done, err}, cnt_bus, cnt_din, iter_count);
      else n_pass++;
      @(negedge Clk);
      RSTn = 1'b1;
      @(negedge Clk);
      snap();
      exp_q.push_back('{iters:1, bs:1, incs:1, rsts:0, wens:1, dones:1, errf:0});
      kick(8'd1, 8'd2, t0);
      wait_idle(100, ex);
      got = collect(); e = exp_q.pop_front();
      n_checks++;
      if (ex !== 1'b0 || got !== e)
         $display("FAIL midreset_rerun_result: got it=%0d bs=%0d inc=%0d done=%0d want it=%0d bs=%0d inc=%0d done=%0d",
                  got.iters, got.bs, got.incs, got.dones, e.iters, e.bs, e.incs, e.dones);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_iter();
      test_timeout();
      test_abort();
      test_coincident();
      test_reset_mid();
      repeat (2) @(negedge Clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
